// File: rtl/lab4_g29_gate_sweep.sv
// -----------------------------------------------------------------------------
// lab4_g29_gate_sweep
// Parametrised N-input logic gate with a built-in exhaustive truth-table
// sweeper. On start, every input vector 0..2^N_IN-1 is applied to the
// selected gate. Each registered output is compared against a latched
// expected truth table. The block counts mismatches and records the lowest
// failing vector.
//
// Optional feature macro: SWEEP_AUTO_REPEAT_EN
//   When defined, this macro adds input repeat_en. With repeat_en=1 the
//   sweep restarts from vector 0 straight out of DONE, using the already
//   latched op and truth table.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin sweep (sampled only in IDLE)
//   op[2:0]      in   gate select: AND, OR, NAND, NOR, XOR, XNOR, 11x -> 0
//   exp_tt       in   expected truth table, bit k = expected y for vec k
//   repeat_en    in   (SWEEP_AUTO_REPEAT_EN only) auto-restart after DONE
//   busy         out  high while applying/sampling vectors
//   done         out  one-cycle pulse at end of sweep
//   vec          out  input vector currently applied
//   y            out  registered gate output
//   mismatch_cnt out  number of failing vectors in last sweep
//   pass         out  last sweep completed with no mismatches
//   first_fail   out  lowest failing vector (valid when mismatch_cnt > 0)
// -----------------------------------------------------------------------------
module lab4_g29_gate_sweep #(
    parameter int unsigned N_IN  = 2,
    parameter int unsigned DWELL = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              op,
    input  logic [(1<<N_IN)-1:0]    exp_tt,
`ifdef SWEEP_AUTO_REPEAT_EN
    input  logic                    repeat_en,
`endif
    output logic                    busy,
    output logic                    done,
    output logic [N_IN-1:0]         vec,
    output logic                    y,
    output logic [N_IN:0]           mismatch_cnt,
    output logic                    pass,
    output logic [N_IN-1:0]         first_fail
);

    localparam int unsigned N_VEC = 1 << N_IN;
    localparam int unsigned CNT_W = N_IN + 1;
    localparam int unsigned DW_W  = (DWELL < 1) ? 1 : $clog2(DWELL + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op_q;
    logic [N_VEC-1:0]    r_tt_q;
    logic [DW_W-1:0]     r_dwell;
    logic [N_IN-1:0]     r_vec;
    logic                r_y;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_mismatch_cnt;
    logic                r_pass;
    logic [N_IN-1:0]     r_first_fail;

    // N-input reduction gate; illegal selects force 0
    function automatic logic f_gate(input logic [2:0] f_op, input logic [N_IN-1:0] f_v);
        logic f_r;
        case (f_op)
            3'b000:  f_r = &f_v;
            3'b001:  f_r = |f_v;
            3'b010:  f_r = ~(&f_v);
            3'b011:  f_r = ~(|f_v);
            3'b100:  f_r = ^f_v;
            3'b101:  f_r = ~(^f_v);
            default: f_r = 1'b0;
        endcase
        return f_r;
    endfunction

    // Sweep FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_op_q         <= 3'b000;
            r_tt_q         <= '0;
            r_dwell        <= '0;
            r_vec          <= '0;
            r_y            <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_mismatch_cnt <= '0;
            r_pass         <= 1'b0;
            r_first_fail   <= '0;
        end else begin
            r_done <= 1'b0;
            // y is one register stage behind vec; DWELL >= 1 guarantees it has settled by SAMPLE
            r_y    <= f_gate(r_op_q, r_vec);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op_q         <= op;
                        r_tt_q         <= exp_tt;
                        r_mismatch_cnt <= '0;
                        r_pass         <= 1'b0;
                        r_first_fail   <= '0;
                        r_vec          <= '0;
                        r_dwell        <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= S_APPLY;
                    end
                end
                S_APPLY: begin
                    r_dwell <= r_dwell + DW_W'(1);
                    if (r_dwell == DW_W'(DWELL - 1)) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (r_y != r_tt_q[r_vec]) begin
                        r_mismatch_cnt <= r_mismatch_cnt + CNT_W'(1);
                        if (r_mismatch_cnt == '0) begin
                            r_first_fail <= r_vec;
                        end
                    end
                    if (r_vec == {N_IN{1'b1}}) begin
                        r_busy  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_vec   <= r_vec + N_IN'(1);
                        r_dwell <= '0;
                        r_state <= S_APPLY;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_pass  <= (r_mismatch_cnt == '0);
                    r_state <= S_IDLE;
`ifdef SWEEP_AUTO_REPEAT_EN
                    // Restart with the latched op/table; results of this sweep are reported by pass
                    if (repeat_en) begin
                        r_vec          <= '0;
                        r_dwell        <= '0;
                        r_mismatch_cnt <= '0;
                        r_first_fail   <= '0;
                        r_busy         <= 1'b1;
                        r_state        <= S_APPLY;
                    end
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign vec          = r_vec;
    assign y            = r_y;
    assign mismatch_cnt = r_mismatch_cnt;
    assign pass         = r_pass;
    assign first_fail   = r_first_fail;

endmodule

// File: doc/lab4_g29_gate_sweep.md
Name: lab4_g29_gate_sweep

Overview:
Parametrised N-input logic gate with a built-in exhaustive truth-table sweeper.
- On `start`, an FSM walks every input vector 0..2^N_IN-1 through the selected gate and registers the output.
- Each output is compared against a caller-supplied expected truth table; mismatches are counted and the first failing vector is recorded.
- Self-checking successor to the 2-input lab gates; sits stand-alone on a lab board or under a bench.

Parameters:
N_IN, 2, number of gate inputs; legal 1..8.
DWELL, 1, cycles each vector is held before sampling; legal >= 1.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE
op  input  3  gate select: 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR, 110/111 illegal (output constant 0)
exp_tt  input  2^N_IN  expected truth table; bit k = expected y for vec == k
busy  output  1  high in APPLY/SAMPLE
done  output  1  one-cycle pulse at end of sweep
vec  output  N_IN  input vector currently applied
y  output  1  registered gate output, y <= gate(op_q, vec) every cycle
mismatch_cnt  output  N_IN+1  number of failing vectors in last sweep
pass  output  1  1 when last sweep completed with mismatch_cnt == 0
first_fail  output  N_IN  lowest failing vector; meaningful only if mismatch_cnt > 0

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, vec=0, y=0, mismatch_cnt=0, pass=0, first_fail=0, dwell counter=0.
- FSM states and transitions:
  - IDLE: on start=1, latch op->op_q and exp_tt->tt_q; clear mismatch_cnt, pass, first_fail; set vec=0, dwell=0; go APPLY.
  - APPLY: dwell increments each cycle. After DWELL cycles in APPLY, go SAMPLE.
  - SAMPLE (one cycle): compare y with tt_q[vec]. On mismatch, increment mismatch_cnt; if this is the first mismatch, set first_fail=vec. If vec == 2^N_IN-1, go DONE; else vec+1, dwell=0, go APPLY.
  - DONE (one cycle): done=1, pass=(mismatch_cnt==0); go IDLE.
- Timing and latency:
  - Each vector occupies DWELL+1 cycles.
  - done rises exactly 2^N_IN*(DWELL+1)+1 rising edges after the edge that sampled start.
- Input handling:
  - op and exp_tt changes mid-sweep have no effect, since they are latched.
  - start while busy or in DONE is ignored.
- Results (mismatch_cnt, pass, first_fail) hold until the next accepted start.
- Width rules:
  - mismatch_cnt saturates naturally: its maximum is 2^N_IN, which fits in N_IN+1 bits.
  - vec does not wrap inside a sweep.
- Reset mid-sweep aborts immediately to IDLE with all outputs at reset values; no done pulse.
- Illegal op (110/111): y=0 for all vectors; the sweep runs normally.

Optional Feature:
Macro: SWEEP_AUTO_REPEAT_EN
- Defined: adds input port `repeat_en` (1 bit). In DONE, if repeat_en=1:
  - done still pulses and pass is updated;
  - the next state is APPLY with vec=0, dwell=0, mismatch_cnt cleared, first_fail cleared;
  - op_q and tt_q are retained, not re-latched.
  - If repeat_en=0, DONE returns to IDLE.
- Not defined: port absent; DONE always returns to IDLE.

Test Plan:
1. N_IN=2, DWELL=1, op=011 (NOR), exp_tt=4'b0001, start pulse -> done at edge 9 after start; pass=1, mismatch_cnt=0.
2. N_IN=2, op=011, exp_tt=4'b0011 -> mismatch_cnt=1, first_fail=2'b01, pass=0; vec sequence observed 0,1,2,3.
3. N_IN=3, DWELL=2, op=100 (XOR), exp_tt=8'h96 -> done at edge 25 after start; pass=1. Repeat with op=101 (XNOR) -> mismatch_cnt=8, first_fail=0.
4. Drop rst_n mid-sweep with vec=2 -> all outputs 0 asynchronously, state IDLE, no done pulse; next start runs a full clean sweep.
5. start held high / re-pulsed during busy, and op changed mid-sweep -> no restart; results reflect the originally latched op.
6. op=111, exp_tt=all zeros -> y stays 0 throughout, pass=1. With SWEEP_AUTO_REPEAT_EN and repeat_en=1 -> done pulses every 2^N_IN*(DWELL+1)+1 cycles continuously.
